// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode: in-order {PC, instr} FIFO
// with AdEL tagging on enqueue, a PC stall output and flush on redirect.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 2,
  parameter logic [31:0] PC_BASE  = 32'h0000_3000,
  parameter logic [31:0] PC_LIMIT = 32'h0000_6FFC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  output logic              in_ready,
  output logic              pc_stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic              out_adel,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [31:0]       pc_mem    [DEPTH];
  logic [31:0]       instr_mem [DEPTH];
  logic              adel_mem  [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic              enq;
  logic              deq;
  logic              in_adel;

  function automatic logic fetch_adel(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < PC_BASE) || (pc > PC_LIMIT);
  endfunction

  // Ready/valid derive from registered occupancy only, so out_ready never reaches in_ready.
  assign in_ready  = (count != FULL_CNT);
  assign pc_stall  = ~in_ready;
  assign out_valid = (count != '0);

  assign enq     = in_valid & in_ready & ~flush & ~reset;
  assign deq     = out_valid & out_ready & ~flush & ~reset;
  assign in_adel = fetch_adel(in_pc);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_ONE;
      if (deq) head <= head + PTR_ONE;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; its contents only matter once count covers them.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail]    <= in_pc;
      instr_mem[tail] <= in_adel ? 32'h0 : in_instr;
      adel_mem[tail]  <= in_adel;
    end
  end

  always_comb begin
    out_pc    = 32'h0;
    out_instr = 32'h0;
    out_adel  = 1'b0;
    if (out_valid) begin
      out_pc    = pc_mem[head];
      out_instr = instr_mem[head];
      out_adel  = adel_mem[head];
    end
  end

endmodule
